// File: rtl/soc_rst_seq.sv
// -----------------------------------------------------------------------------
// soc_rst_seq -- SoC reset sequencer
//
// Purpose:
//   Releases NumDomains active-low domain resets one after another, spaced
//   ReleaseGap cycles apart, after rst_i falls. It then waits for the
//   synchronized boot enable, raises the sticky fetch_en_o / boot_done_o pair
//   and sits in RUN. Also provides a bank of NumSyncIn plain input
//   synchronizers.
//
// Optional feature (macro SOC_RST_SEQ_SWRST_EN):
//   When defined, each domain can be pulsed back into reset from RUN through
//   sw_rst_req_i[k]. The domain is held low for ReleaseGap cycles after the
//   last cycle the request was seen high. When undefined, sw_rst_req_i is
//   ignored and no per-domain counters are built.
//
// Ports:
//   clk_i          single clock
//   rst_i          asynchronous active-high reset
//   testmode_i     DFT bypass: domain_rst_no follows ~rst_i combinationally
//   fetch_en_i     async boot enable (synchronized internally)
//   sw_rst_req_i   per-domain software reset request (synchronous level)
//   sync_in_i      async general inputs
//   sync_out_o     synchronized copy of sync_in_i
//   domain_rst_no  per-domain reset, active-low
//   fetch_en_o     synchronized, gated, sticky fetch enable to the core
//   boot_done_o    high once the boot sequence has completed
//   state_o        FSM state: 0 RESET, 1 RELEASE, 2 WAIT_FETCH, 3 RUN
// -----------------------------------------------------------------------------

// Single-bit synchronizer: Stages-deep flop chain, cleared by reset.
module soc_rst_seq_sync #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[Stages-2:0], d_i};
    end

    assign q_o = sync_q[Stages-1];
endmodule

module soc_rst_seq #(
    parameter int NumDomains = 2,
    parameter int ReleaseGap = 16,
    parameter int SyncStages = 2,
    parameter int NumSyncIn  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  testmode_i,
    input  logic                  fetch_en_i,
    input  logic [NumDomains-1:0] sw_rst_req_i,
    input  logic [NumSyncIn-1:0]  sync_in_i,
    output logic [NumSyncIn-1:0]  sync_out_o,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  fetch_en_o,
    output logic                  boot_done_o,
    output logic [1:0]            state_o
);
    localparam int              IdxW    = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDomains - 1);
    localparam logic [7:0]      GapM1   = 8'(ReleaseGap - 1);

    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_RELEASE    = 2'd1,
        ST_WAIT_FETCH = 2'd2,
        ST_RUN        = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NumDomains-1:0]   rst_n_q, rst_n_d;
    logic                    fetch_q, fetch_d;
    logic                    done_q, done_d;
    logic                    fetch_sync;

    // ---------------------------------------------------------------------
    // Input synchronizers, one instance per bit
    // ---------------------------------------------------------------------
    soc_rst_seq_sync #(.Stages(SyncStages)) u_sync_fetch (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (fetch_en_i),
        .q_o   (fetch_sync)
    );

    for (genvar i = 0; i < NumSyncIn; i++) begin : g_sync_in
        soc_rst_seq_sync #(.Stages(SyncStages)) u_sync (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (sync_in_i[i]),
            .q_o   (sync_out_o[i])
        );
    end

`ifdef SOC_RST_SEQ_SWRST_EN
    // Per-domain hold counters for software resets. Zero means idle.
    localparam logic [7:0] Gap8 = 8'(ReleaseGap);

    logic [NumDomains-1:0][7:0] sw_cnt_q, sw_cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sw_cnt_q <= '0;
        else       sw_cnt_q <= sw_cnt_d;
    end
`else
    logic unused_sw_rst;
    assign unused_sw_rst = ^sw_rst_req_i;
`endif

    // ---------------------------------------------------------------------
    // FSM state and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RESET;
            idx_q   <= '0;
            cnt_q   <= '0;
            rst_n_q <= '0;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            fetch_q <= fetch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        fetch_d = fetch_q;
        done_d  = done_q;
`ifdef SOC_RST_SEQ_SWRST_EN
        sw_cnt_d = sw_cnt_q;
`endif
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_RELEASE;
                idx_d   = '0;
                cnt_d   = '0;
            end
            ST_RELEASE: begin
                // One domain per ReleaseGap cycles, in index order.
                if (cnt_q == GapM1) begin
                    rst_n_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = ST_WAIT_FETCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_FETCH: begin
                // An enable that arrived early is simply seen here, one edge
                // after entry.
                if (fetch_sync) begin
                    state_d = ST_RUN;
                    fetch_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
`ifdef SOC_RST_SEQ_SWRST_EN
                // A request reloads the counter every cycle it is high; the
                // domain comes back on the edge the counter reaches zero.
                for (int k = 0; k < NumDomains; k++) begin
                    if (sw_rst_req_i[k]) begin
                        rst_n_d[k]  = 1'b0;
                        sw_cnt_d[k] = Gap8;
                    end else if (sw_cnt_q[k] != 8'd0) begin
                        sw_cnt_d[k] = sw_cnt_q[k] - 8'd1;
                        if (sw_cnt_q[k] == 8'd1) rst_n_d[k] = 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_RESET;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // DFT bypass hands domain resets straight to the chip reset pin.
    assign domain_rst_no = testmode_i ? {NumDomains{~rst_i}} : rst_n_q;
    assign fetch_en_o    = fetch_q;
    assign boot_done_o   = done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_soc_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_soc_rst_seq -- self-checking bench for soc_rst_seq (default parameters).
// The reference model works in absolute edge numbers counted from reset
// release: release times, the run entry edge and the last software request
// per domain are enough to derive every output.
// -----------------------------------------------------------------------------
module tb_soc_rst_seq;
    localparam int N = 2;
    localparam int G = 16;
    localparam int S = 2;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         testmode_i;
    logic         fetch_en_i;
    logic [N-1:0] sw_rst_req_i;
    logic [M-1:0] sync_in_i;
    logic [M-1:0] sync_out_o;
    logic [N-1:0] domain_rst_no;
    logic         fetch_en_o;
    logic         boot_done_o;
    logic [1:0]   state_o;

    always #5 clk = ~clk;

    soc_rst_seq #(
        .NumDomains (N),
        .ReleaseGap (G),
        .SyncStages (S),
        .NumSyncIn  (M)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .testmode_i    (testmode_i),
        .fetch_en_i    (fetch_en_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .sync_in_i     (sync_in_i),
        .sync_out_o    (sync_out_o),
        .domain_rst_no (domain_rst_no),
        .fetch_en_o    (fetch_en_o),
        .boot_done_o   (boot_done_o),
        .state_o       (state_o)
    );

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           e;             // edge number since reset release, -1 = none
    int           run_edge;      // edge at which RUN was entered, -1 = not yet
    int           last_req[N];   // last edge a software request was taken
    bit           fe_hist[2048];
    logic [M-1:0] si_hist[2048];

    task automatic model_reset();
        e        = -1;
        run_edge = -1;
        for (int k = 0; k < N; k++) last_req[k] = -1000;
    endtask

    task automatic model_step();
        e++;
        fe_hist[e] = fetch_en_i;
        si_hist[e] = sync_in_i;
`ifdef SOC_RST_SEQ_SWRST_EN
        if (run_edge >= 0 && e > run_edge)
            for (int k = 0; k < N; k++)
                if (sw_rst_req_i[k]) last_req[k] = e;
`endif
        // FSM sees the input sampled S edges earlier.
        if (run_edge < 0 && e >= N*G + 1 && e - S >= 0 && fe_hist[e-S]) run_edge = e;
    endtask

    task automatic check_all();
        logic [1:0]   es;
        logic [N-1:0] ed;
        logic [M-1:0] eso;
        logic         ef;
        if (e < 0)                          es = 2'd0;
        else if (e < N*G)                   es = 2'd1;
        else if (run_edge < 0 || e < run_edge) es = 2'd2;
        else                                es = 2'd3;
        for (int k = 0; k < N; k++)
            ed[k] = (e >= (k+1)*G) && (e >= last_req[k] + G);
        if (testmode_i) ed = {N{~rst_i}};
        eso = (e - S + 1 >= 0) ? si_hist[e-S+1] : '0;
        ef  = (run_edge >= 0) && (e >= run_edge);
        chk("state", 32'(state_o), 32'(es));
        chk("domain_rst_n", 32'(domain_rst_no), 32'(ed));
        chk("fetch_en", 32'(fetch_en_o), 32'(ef));
        chk("boot_done", 32'(boot_done_o), 32'(ef));
        chk("sync_out", 32'(sync_out_o), 32'(eso));
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_rst(input bit tm_dir);
        #2;
        if (tm_dir) begin
            testmode_i = 1'b1;
            #1;
            chk("tm_bypass_hi", 32'(domain_rst_no), 32'({N{1'b1}}));
        end
        rst_i = 1'b1;
        #1;
        chk("async_dom", 32'(domain_rst_no), 32'(0));
        chk("async_state", 32'(state_o), 32'(0));
        chk("async_fetch", 32'(fetch_en_o), 32'(0));
        chk("async_done", 32'(boot_done_o), 32'(0));
        chk("async_sync", 32'(sync_out_o), 32'(0));
        model_reset();
        testmode_i   = 1'b0;
        sw_rst_req_i = '0;
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        rst_i = 1'b0;
    endtask

    // mode 0: fetch_en_i high throughout; mode 1: fetch window [100,200);
    // mode 2: random fetch_en_i and testmode_i.
    task automatic run_seq(input int n, input int mode, input int rst_at, input bit tm_dir);
        int nxt;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (!rst_i) model_step();
            @(negedge clk);
            check_all();
            if (mode == 0) begin
                if (e == 15) chk("rel0_early", 32'(domain_rst_no), 32'(2'b00));
                if (e == 16) chk("rel0_at16", 32'(domain_rst_no), 32'(2'b01));
                if (e == 31) chk("rel1_early", 32'(domain_rst_no), 32'(2'b01));
                if (e == 32) chk("rel1_at32", 32'(domain_rst_no), 32'(2'b11));
                if (e == 32) chk("wait_at32", 32'(state_o), 32'(2));
                if (e == 32) chk("fetch_at32", 32'(fetch_en_o), 32'(0));
                if (e == 33) chk("fetch_at33", 32'(fetch_en_o), 32'(1));
                if (e == 33) chk("done_at33", 32'(boot_done_o), 32'(1));
`ifdef SOC_RST_SEQ_SWRST_EN
                if (e == 60) chk("swrst_lo_60", 32'(domain_rst_no), 32'(2'b01));
                if (e == 75) chk("swrst_lo_75", 32'(domain_rst_no), 32'(2'b01));
                if (e == 76) chk("swrst_back_76", 32'(domain_rst_no), 32'(2'b11));
                if (e == 70) chk("swrst_run", 32'(state_o), 32'(3));
`else
                if (e == 60) chk("noswrst_60", 32'(domain_rst_no), 32'(2'b11));
`endif
            end
            if (mode == 1) begin
                if (e == 101) chk("fe_sync_101", 32'(fetch_en_o), 32'(0));
                if (e == 102) chk("fe_sync_102", 32'(fetch_en_o), 32'(1));
                if (e == 210) chk("fe_sticky", 32'(fetch_en_o), 32'(1));
            end
            if (rst_at >= 0 && e == rst_at) begin
                pulse_rst(tm_dir);
                return;
            end
            nxt       = e + 1;
            sync_in_i = M'($urandom);
            for (int k = 0; k < N; k++) sw_rst_req_i[k] = ($urandom_range(0, 15) == 0);
            case (mode)
                0: begin
                    fetch_en_i = 1'b1;
                    if (nxt == 60) sw_rst_req_i = 2'b10;
                    else if (nxt >= 40 && nxt < 80) sw_rst_req_i = '0;
                end
                1: fetch_en_i = (nxt >= 100 && nxt < 200);
                default: begin
                    fetch_en_i = ($urandom_range(0, 3) == 0);
                    testmode_i = ($urandom_range(0, 7) == 0);
                end
            endcase
        end
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        rst_i        = 1'b1;
        testmode_i   = 1'b0;
        fetch_en_i   = 1'b1;
        sw_rst_req_i = '0;
        sync_in_i    = '0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all();
            sync_in_i = M'($urandom);
        end
        rst_i = 1'b0;

        run_seq(90, 0, -1, 1'b0);   // boot, run, directed software reset
        pulse_rst(1'b0);
        run_seq(40, 0, 20, 1'b0);   // reset pulsed mid-release
        run_seq(260, 1, 230, 1'b0); // delayed fetch enable, reset in RUN
        run_seq(40, 2, 5, 1'b1);    // testmode bypass during RELEASE
        run_seq(300, 2, 250, 1'b0); // random traffic

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/soc_rst_seq.md
SOC_RST_SEQ -- requirements
Module: soc_rst_seq

Interface
REQ-001 Parameter NumDomains, default 2, number of sequenced reset domains; the block SHALL support 1..8.
REQ-002 Parameter ReleaseGap, default 16, cycles between successive domain releases and the software-reset hold time; the block SHALL support 1..255.
REQ-003 Parameter SyncStages, default 2, synchronizer depth for all async inputs; the block SHALL support 2..4.
REQ-004 Parameter NumSyncIn, default 16, number of general async inputs synchronized; the block SHALL support 1..32.
REQ-005 Ports SHALL be as follows; clock and reset are listed first:
- clk_i  in  1  the single clock
- rst_i  in  1  reset, asynchronous, active-high
- testmode_i  in  1  DFT bypass
- fetch_en_i  in  1  async boot enable
- sw_rst_req_i  in  NumDomains  per-domain software reset request, synchronous level
- sync_in_i  in  NumSyncIn  async general inputs
- sync_out_o  out  NumSyncIn  synchronized copy of sync_in_i
- domain_rst_no  out  NumDomains  per-domain reset, active-low
- fetch_en_o  out  1  synchronized, gated fetch enable to core
- boot_done_o  out  1  high once sequence complete
- state_o  out  2  FSM state: 0 RESET, 1 RELEASE, 2 WAIT_FETCH, 3 RUN

Function
REQ-006 The FSM SHALL have states RESET, RELEASE, WAIT_FETCH and RUN, encoded as in REQ-005.
REQ-007 Edge 0 is the first rising clk_i edge with rst_i low; at edge 0 the FSM SHALL move RESET->RELEASE with index=0 and counter=0.
REQ-008 In RELEASE the counter SHALL increment every cycle; at the edge where counter==ReleaseGap-1, domain_rst_no[index] SHALL go 1, index SHALL increment and counter SHALL return to 0.
REQ-009 Domain k SHALL therefore be released at edge (k+1)*ReleaseGap and never earlier than domain k-1.
REQ-010 On the edge releasing domain NumDomains-1, the FSM SHALL enter WAIT_FETCH.
REQ-011 fetch_en_i and every sync_in_i bit SHALL pass through a SyncStages-deep flop chain reset to 0; sync_out_o latency SHALL be exactly SyncStages edges.
REQ-012 In WAIT_FETCH, when synchronized fetch_en is 1, the FSM SHALL enter RUN, and fetch_en_o and boot_done_o SHALL rise on that same edge.
REQ-013 fetch_en_o and boot_done_o SHALL be sticky in RUN; a later low on fetch_en_i SHALL not clear them; only rst_i SHALL clear them.
REQ-014 Synchronized fetch_en asserted during RESET or RELEASE SHALL be held off until WAIT_FETCH, giving a transition one edge after entry.
REQ-015 In RUN, sw_rst_req_i[k]=1 sampled at an edge SHALL drive domain_rst_no[k] to 0 at that edge and load per-domain counter k with ReleaseGap.
REQ-016 Per-domain counter k SHALL decrement while sw_rst_req_i[k]=0; domain_rst_no[k] SHALL return to 1 on the edge it reaches 0. A request held high SHALL reload the counter every cycle, so the domain is held in reset.
REQ-017 Software requests in states other than RUN SHALL be ignored; simultaneous requests on several domains SHALL be handled independently.
REQ-018 FSM state SHALL remain RUN during software resets; fetch_en_o and boot_done_o SHALL be unaffected.
REQ-019 When testmode_i=1, domain_rst_no SHALL equal ~rst_i on every bit combinationally; all other logic SHALL be unchanged.

Reset
REQ-020 While rst_i=1, regardless of clock, the block SHALL drive: state RESET, domain_rst_no all 0, fetch_en_o 0, boot_done_o 0, sync_out_o 0, all sync flops and counters 0.
REQ-021 rst_i asserted mid-sequence or in RUN SHALL immediately force REQ-020 values; the full sequence SHALL restart from edge 0 after deassertion.

Configuration
REQ-022 With SOC_RST_SEQ_SWRST_EN defined, the block SHALL implement REQ-015..REQ-018.
REQ-023 Without SOC_RST_SEQ_SWRST_EN, sw_rst_req_i SHALL be ignored, no per-domain counters SHALL exist, and domain_rst_no SHALL stay 1 in RUN until rst_i.

Verification
REQ-024 Defaults, fetch_en_i=1 throughout, rst_i falls -> domain_rst_no[0] rises at edge 16, [1] at edge 32; state WAIT_FETCH at 32; fetch_en_o and boot_done_o rise at edge 33.
REQ-025 fetch_en_i rises at edge 100 -> fetch_en_o rises 2-3 edges later (sync); fetch_en_i drops at 200 -> fetch_en_o stays 1.
REQ-026 Macro defined, RUN, one-cycle sw_rst_req_i=2'b10 -> domain_rst_no[1]=0 for 16 cycles and domain 0 stays 1; same pulse in RELEASE -> no effect.
REQ-027 rst_i pulsed at edge 20 -> all outputs 0 asynchronously; after deassertion domain 0 releases 16 edges later.
REQ-028 testmode_i=1 during RELEASE -> domain_rst_no=2'b11 immediately; rst_i=1 -> 2'b00 without a clock edge.
